// File: rtl/rho_rotator.sv
// rho_rotator
//   Rho step of a Keccak-style permutation, arranged as a page-serial
//   stream. A burst of 64 pages arrives from the theta stage. Page z carries
//   bit z of all 25 lanes, with lane (x,y) at bit 5*y+x. The burst is
//   collected into 25 lane registers of 64 bits each. The block then emits 64
//   pages. In output page z, bit i is lane i rotated left by r[i], which is
//   lane i bit (z - r[i]) mod 64.
//
// Ports
//   clk       system clock, rising-edge active
//   rst       asynchronous reset, active low
//   inStart   one-cycle burst announce from theta; honoured only in Idle
//   inValid   inPage qualifier; honoured only in Capture
//   inPage    theta page z (25 bits, bit 5*y+x = lane (x,y) bit z)
//   ready     high only in Idle
//   outValid  outPage holds a rotated page (Emit only)
//   outAck    consumer takes outPage when outValid & outAck
//   outPage   rotated page z; same bit layout as inPage; 0 when not valid
//   done      one-cycle pulse after the 64th page is taken
//   dbg_state FSM state (0 Idle, 1 Capture, 2 Emit, 3 Finish)
//
// Handshake: the input side has no backpressure. Each inValid cycle in
// Capture stores one page. The output side uses valid/ready semantics.
// outValid stays high through Emit, and outPage holds stable until a cycle
// with outValid & outAck. No page is lost or repeated.
module rho_rotator (
  input  logic        clk,
  input  logic        rst,
  input  logic        inStart,
  input  logic        inValid,
  input  logic [24:0] inPage,
  output logic        ready,
  output logic        outValid,
  input  logic        outAck,
  output logic [24:0] outPage,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_EMIT    = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  in_cnt;
  logic [5:0]  out_cnt;
  logic [63:0] lanes [25];

  logic        cap_en;
  logic        emit_adv;
  logic [5:0]  src_idx [25];
  logic [24:0] rot_page;

  // Rho rotation offset of lane i = 5*y + x.
  function automatic logic [5:0] rot_off(input int idx);
    case (idx)
      0:  return 6'd0;
      1:  return 6'd1;
      2:  return 6'd62;
      3:  return 6'd28;
      4:  return 6'd27;
      5:  return 6'd36;
      6:  return 6'd44;
      7:  return 6'd6;
      8:  return 6'd55;
      9:  return 6'd20;
      10: return 6'd3;
      11: return 6'd10;
      12: return 6'd43;
      13: return 6'd25;
      14: return 6'd39;
      15: return 6'd41;
      16: return 6'd45;
      17: return 6'd15;
      18: return 6'd21;
      19: return 6'd8;
      20: return 6'd18;
      21: return 6'd2;
      22: return 6'd61;
      23: return 6'd56;
      24: return 6'd14;
      default: return 6'd0;
    endcase
  endfunction

  assign dbg_state = state_q;
  assign cap_en    = (state_q == S_CAPTURE) && inValid;
  assign emit_adv  = (state_q == S_EMIT) && outAck;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    outValid = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (inStart) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (inValid && (in_cnt == 6'd63)) state_d = S_EMIT;
      end
      S_EMIT: begin
        outValid = 1'b1;
        if (outAck && (out_cnt == 6'd63)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Page counters. The input counter is cleared on burst start. The output
  // counter is cleared as the last page is captured, so Emit always starts
  // at z = 0. Both wrap naturally at 64.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt  <= 6'd0;
      out_cnt <= 6'd0;
    end else begin
      if ((state_q == S_IDLE) && inStart) begin
        in_cnt <= 6'd0;
      end else if (cap_en) begin
        in_cnt <= in_cnt + 6'd1;
      end

      if (cap_en && (in_cnt == 6'd63)) begin
        out_cnt <= 6'd0;
      end else if (emit_adv) begin
        out_cnt <= out_cnt + 6'd1;
      end
    end
  end

  // Lane storage. Captured page z writes bit z of every lane. Contents are
  // kept after Finish until the next burst overwrites them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 25; i++) begin
        lanes[i] <= 64'd0;
      end
    end else if (cap_en) begin
      for (int i = 0; i < 25; i++) begin
        lanes[i][in_cnt] <= inPage[i];
      end
    end
  end

  // Rotated page. The 6-bit subtraction gives the mod-64 wrap. The page is
  // purely combinational, so it is valid in the first Emit cycle.
  always_comb begin
    rot_page = '0;
    for (int i = 0; i < 25; i++) begin
      src_idx[i]  = out_cnt - rot_off(i);
      rot_page[i] = lanes[i][src_idx[i]];
    end
  end

  assign outPage = outValid ? rot_page : 25'd0;

endmodule
